// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and grant-source constants for the write-port arbiter
package wb_arb_pkg;
    typedef enum logic {NORMAL, DRAIN} state_e;
    localparam logic GRANT_PIPE = 1'b0;
    localparam logic GRANT_LU   = 1'b1;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO with modulo-depth pointers and an occupancy counter
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    // storage is not reset; only pointers and occupancy define validity
    always_ff @(posedge clk) mem_q <= mem_d;
    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between write-back and a buffered long-latency unit
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [ADDR_W-1:0]             pipe_rd,
    input  logic [DATA_W-1:0]             pipe_data,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [ADDR_W-1:0]             lu_rd,
    input  logic [DATA_W-1:0]             lu_data,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_rd,
    output logic [DATA_W-1:0]             rf_wd,
    output logic                          grant_src,
    output logic                          stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;
    entry_t            din, head;
    logic              full, empty, push, pop, pipe_go;
    logic [CW-1:0]     count;
    state_e            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              rf_we_q, rf_we_d, grant_q, grant_d, stall_q, stall_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
        .head(head), .count(count), .full(full), .empty(empty)
    );
    // grant selection, wait tracking and drain control; rd==0 results are dropped
    always_comb begin
        din     = '{rd: lu_rd, data: lu_data};
        push    = lu_valid && !full && lu_rd != '0;
        pipe_go = state_q == NORMAL && pipe_we && pipe_rd != '0;
        pop     = !empty && (state_q == DRAIN || !pipe_go);
        rf_we_d = pipe_go || pop;
        rf_rd_d = pipe_go ? pipe_rd : pop ? head.rd : rf_rd_q;
        rf_wd_d = pipe_go ? pipe_data : pop ? head.data : rf_wd_q;
        grant_d = pipe_go ? GRANT_PIPE : pop ? GRANT_LU : grant_q;
        wait_d  = (state_q == NORMAL && !empty && !pop) ? wait_q + WW'(1) : '0;
        state_d = state_q == NORMAL ? (wait_d == WW'(MAX_WAIT) ? DRAIN : NORMAL)
                                    : ((count == CW'(1) && !push) ? NORMAL : DRAIN);
        stall_d = state_d == DRAIN;
    end
    // state and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            wait_q  <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
            grant_q <= GRANT_PIPE;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
        end
    end
    assign lu_ready   = !full;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wd      = rf_wd_q;
    assign grant_src  = grant_q;
    assign stall_req  = stall_q;
    assign fifo_count = count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random checks of the arbiter against a queue-based model
module tb_wb_port_arbiter;
    localparam int DW = 32, AW = 5, DEPTH = 2, MW = 4;
    logic clk = 0, rst = 1;
    logic pipe_we = 0, lu_valid = 0;
    logic [AW-1:0] pipe_rd = 0, lu_rd = 0;
    logic [DW-1:0] pipe_data = 0, lu_data = 0;
    logic lu_ready, rf_we, grant_src, stall_req;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wd;
    logic [$clog2(DEPTH):0] fifo_count;
    int checks = 0, errors = 0;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .grant_src(grant_src),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: a queue of pending results and a count of consecutive denials
    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
    ent_t q[$];
    bit drain = 0, started = 0;
    int denied = 0;
    logic m_we = 0, m_gs = 0;
    logic [AW-1:0] m_rd = 0;
    logic [DW-1:0] m_wd = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            drain = 0; denied = 0; started = 1;
            m_we = 0; m_rd = 0; m_wd = 0; m_gs = 0;
        end else begin
            automatic int sz = q.size();
            automatic bit ready = sz < DEPTH;
            automatic bit pg = !drain && pipe_we && pipe_rd != 0;
            automatic bit pp = sz > 0 && (drain || !pg);
            if (pg) begin
                m_we = 1; m_rd = pipe_rd; m_wd = pipe_data; m_gs = 0;
            end else if (pp) begin
                automatic ent_t e = q.pop_front();
                m_we = 1; m_rd = e.rd; m_wd = e.data; m_gs = 1;
            end else m_we = 0;
            if (lu_valid && ready && lu_rd != 0) q.push_back('{lu_rd, lu_data});
            if (!drain) begin
                denied = (sz > 0 && !pp) ? denied + 1 : 0;
                if (denied == MW) begin
                    drain = 1; denied = 0;
                end
            end else if (q.size() == 0) drain = 0;
        end
        #1;
        if (started) begin
            chk("rf_we", rf_we, m_we);
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_wd", rf_wd, m_wd);
            if (m_we) chk("grant_src", grant_src, m_gs);
            chk("stall_req", stall_req, drain);
            chk("fifo_count", fifo_count, q.size());
            chk("lu_ready", lu_ready, q.size() < DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        pipe_we = 0; pipe_rd = 0; pipe_data = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    endtask

    initial begin
        // reset with requests active
        rst = 1; pipe_we = 1; pipe_rd = 5; pipe_data = 32'h55; lu_valid = 1; lu_rd = 3; lu_data = 32'h66;
        tick(); tick();
        rst = 0; idle();
        chk("rst rf_we", rf_we, 0);
        chk("rst rf_rd", rf_rd, 0);
        chk("rst rf_wd", rf_wd, 0);
        chk("rst grant", grant_src, 0);
        chk("rst stall", stall_req, 0);
        chk("rst count", fifo_count, 0);
        chk("rst ready", lu_ready, 1);
        tick();
        chk("post rst no write", rf_we, 0);
        // pipeline only
        pipe_we = 1; pipe_rd = 5; pipe_data = 32'h1234;
        tick();
        chk("pipe we", rf_we, 1);
        chk("pipe rd", rf_rd, 5);
        chk("pipe wd", rf_wd, 32'h1234);
        chk("pipe src", grant_src, 0);
        pipe_rd = 0;
        tick();
        chk("pipe rd0 no write", rf_we, 0);
        idle();
        // long-latency only
        lu_valid = 1; lu_rd = 7; lu_data = 32'hDEADBEEF;
        tick();
        idle();
        chk("lu queued", fifo_count, 1);
        chk("lu not yet", rf_we, 0);
        tick();
        chk("lu we", rf_we, 1);
        chk("lu src", grant_src, 1);
        chk("lu rd", rf_rd, 7);
        chk("lu wd", rf_wd, 32'hDEADBEEF);
        chk("lu drained", fifo_count, 0);
        lu_valid = 1; lu_rd = 0; lu_data = 32'h99;
        tick();
        idle();
        chk("lu rd0 dropped", fifo_count, 0);
        tick();
        chk("lu rd0 no write", rf_we, 0);
        // starvation forces a one-cycle drain
        pipe_we = 1; pipe_rd = 9; pipe_data = 32'h900; lu_valid = 1; lu_rd = 4; lu_data = 32'hAAAA;
        tick();
        lu_valid = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("starve no stall", stall_req, 0);
        end
        tick();
        chk("starve stall", stall_req, 1);
        chk("starve pipe src", grant_src, 0);
        tick();
        chk("starve stall drop", stall_req, 0);
        chk("starve lu src", grant_src, 1);
        chk("starve lu rd", rf_rd, 4);
        chk("starve lu wd", rf_wd, 32'hAAAA);
        tick();
        chk("starve resume src", grant_src, 0);
        chk("starve resume rd", rf_rd, 9);
        // full FIFO: third push held off until a drain pop
        pipe_rd = 10; lu_valid = 1; lu_rd = 11; lu_data = 32'hB11;
        tick();
        lu_rd = 12; lu_data = 32'hB12;
        tick();
        lu_rd = 13; lu_data = 32'hB13;
        chk("full count", fifo_count, 2);
        chk("full ready", lu_ready, 0);
        tick(); tick(); tick();
        chk("full stall", stall_req, 1);
        chk("full still blocked", lu_ready, 0);
        tick();
        chk("full first out", rf_rd, 11);
        chk("full ready after pop", lu_ready, 1);
        tick();
        lu_valid = 0;
        chk("full second out", rf_rd, 12);
        chk("full stays drain", stall_req, 1);
        chk("full third in", fifo_count, 1);
        tick();
        chk("full third out", rf_rd, 13);
        chk("full drain end", stall_req, 0);
        // reset in the middle of a drain with two entries queued
        pipe_rd = 10; lu_valid = 1; lu_rd = 14; lu_data = 32'hC14;
        tick();
        lu_rd = 15; lu_data = 32'hC15;
        tick();
        lu_valid = 0;
        begin
            int n = 0;
            while (!stall_req && n < 20) begin
                tick();
                n++;
            end
            chk("reach drain", stall_req, 1);
        end
        chk("drain count", fifo_count, 2);
        rst = 1;
        tick();
        rst = 0; idle();
        chk("mid rst stall", stall_req, 0);
        chk("mid rst count", fifo_count, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid rst no write", rf_we, 0);
        end
        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            pipe_we = $urandom_range(0, 3) != 0;
            pipe_rd = $urandom_range(0, 5) == 0 ? '0 : AW'($urandom);
            pipe_data = $urandom;
            lu_valid = $urandom_range(0, 1) == 1;
            lu_rd = $urandom_range(0, 5) == 0 ? '0 : AW'($urandom);
            lu_data = $urandom;
            tick();
        end
        rst = 0; idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
